// File: rtl/key_led_ctrl.sv
// rtl/key_led_ctrl.sv - single-key debounced mode selector driving an 8-bit LED pattern stage
module key_led_ctrl #(
  parameter int DEBOUNCE_CYCLES = 540000,
  parameter int STEP_CYCLES     = 6750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic [1:0] ctrl,
  output logic [7:0] led
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          key_s_q, key_s_d;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press_q, press_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [1:0]    ctrl_prev_q, ctrl_prev_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [7:0]    led_q, led_d;

  // Synchronise the raw key and accept a new level only after it has persisted long enough.
  always_comb begin
    sync1_d  = key;
    key_s_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    press_d  = 1'b0;
    if (key_s_q == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_d     = key_s_q;
      db_cnt_d = '0;
      // Only the pressed direction (debounced 1 -> 0) is an event.
      press_d  = ~key_s_q;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  // Each press advances the mode; 2-bit arithmetic gives the 3 -> 0 wrap.
  always_comb begin
    ctrl_d = press_q ? ctrl_q + 2'd1 : ctrl_q;
  end

  // LED pattern stage: a mode change reloads the pattern and restarts the step timer,
  // taking priority over a step tick landing on the same clock.
  always_comb begin
    ctrl_prev_d = ctrl_q;
    step_cnt_d  = step_cnt_q;
    led_d       = led_q;
    if (ctrl_q != ctrl_prev_q) begin
      step_cnt_d = '0;
      case (ctrl_q)
        2'd0:    led_d = 8'h00;
        2'd1:    led_d = 8'h01;
        2'd2:    led_d = 8'h80;
        default: led_d = 8'hFF;
      endcase
    end else if (step_cnt_q == STEP_LAST) begin
      step_cnt_d = '0;
      case (ctrl_q)
        2'd0:    led_d = 8'h00;
        2'd1:    led_d = {led_q[6:0], led_q[7]};
        2'd2:    led_d = {led_q[0], led_q[7:1]};
        default: led_d = ~led_q;
      endcase
    end else begin
      step_cnt_d = step_cnt_q + SW'(1);
    end
  end

  // State registers; synchroniser and debounced level reset to the released state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      key_s_q     <= 1'b1;
      db_q        <= 1'b1;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      ctrl_q      <= 2'd0;
      ctrl_prev_q <= 2'd0;
      step_cnt_q  <= '0;
      led_q       <= 8'h00;
    end else begin
      sync1_q     <= sync1_d;
      key_s_q     <= key_s_d;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      ctrl_q      <= ctrl_d;
      ctrl_prev_q <= ctrl_prev_d;
      step_cnt_q  <= step_cnt_d;
      led_q       <= led_d;
    end
  end

  assign ctrl = ctrl_q;
  assign led  = led_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb/tb_key_led_ctrl.sv - randomized self-checking bench for key_led_ctrl against a window-based model
module tb_key_led_ctrl;

  localparam int DB   = 8;
  localparam int STEP = 16;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic [1:0] ctrl;
  logic [7:0] led;

  int checks;
  int errors;

  // model state
  int   t;
  logic hist [0:DB];
  logic db_m;
  bit   press_pend;
  bit   load_pend;
  int   ctrl_m;
  int   led_mode;
  int   load_edge;

  key_led_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key(key),
    .ctrl(ctrl),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %h expected %h", tag, t, obs, exp);
    end
  endtask

  // Pattern shown n steps after a mode's pattern was loaded.
  function automatic logic [7:0] pat(input int mode, input int n);
    logic [7:0] one;
    logic [7:0] top;
    one = 8'h01;
    top = 8'h80;
    case (mode)
      1:       return one << (n % 8);
      2:       return top >> (n % 8);
      3:       return (n % 2 == 1) ? 8'h00 : 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] led_exp();
    return pat(led_mode, (t - load_edge) / STEP);
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= DB; j++) hist[j] = 1'b1;
    db_m       = 1'b1;
    press_pend = 1'b0;
    load_pend  = 1'b0;
    ctrl_m     = 0;
    led_mode   = 0;
    load_edge  = t;
  endtask

  // One rising edge: the key is accepted once the last DB synchronised samples all disagree
  // with the debounced level; mode follows one clock later, pattern reload one clock after that.
  task automatic model_edge(input logic kv);
    bit acc;
    acc = 1'b1;
    for (int j = 1; j <= DB; j++) if (hist[j] == db_m) acc = 1'b0;
    if (load_pend) begin
      led_mode  = ctrl_m;
      load_edge = t;
      load_pend = 1'b0;
    end
    if (press_pend) begin
      ctrl_m     = (ctrl_m + 1) % 4;
      load_pend  = 1'b1;
      press_pend = 1'b0;
    end
    if (acc) begin
      db_m = ~db_m;
      if (db_m == 1'b0) press_pend = 1'b1;
    end
    for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
    hist[0] = kv;
  endtask

  // Drive key from the falling edge, advance model on the rising edge, compare at the next falling edge.
  task automatic cyc(input logic kv);
    key = kv;
    @(posedge clk);
    t++;
    if (!rst_n) model_reset();
    else model_edge(kv);
    @(negedge clk);
    chk("ctrl", 8'(ctrl), 8'(ctrl_m));
    chk("led", led, led_exp());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) cyc(1'b1);
    rst_n = 1'b1;
  endtask

  task automatic press(input int low, input int high);
    repeat (low) cyc(1'b0);
    repeat (high) cyc(1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    t      = 0;
    rst_n  = 1'b0;
    key    = 1'b1;
    model_reset();
    @(negedge clk);

    // reset state and idle
    do_reset();
    chk("rst_ctrl", 8'(ctrl), 8'h00);
    chk("rst_led", led, 8'h00);
    repeat (5 * STEP) cyc(1'b1);
    chk("idle_led", led, 8'h00);

    // clean press, rotate-left including wrap
    repeat (DB + 4) cyc(1'b0);
    chk("t2_ctrl", 8'(ctrl), 8'h01);
    repeat (28) cyc(1'b0);
    repeat (9 * STEP) cyc(1'b1);

    // glitches then a long hold
    repeat (10) begin
      repeat (3) cyc(1'b0);
      repeat (2) cyc(1'b1);
    end
    chk("t3_glitch", 8'(ctrl), 8'h01);
    press(200, 30);
    chk("t3_hold", 8'(ctrl), 8'h02);

    // four presses from reset
    do_reset();
    press(20, 3 * STEP + 4);
    chk("t4_m1", 8'(ctrl), 8'h01);
    press(20, 3 * STEP + 4);
    chk("t4_m2", 8'(ctrl), 8'h02);
    press(20, 3 * STEP + 4);
    chk("t4_m3", 8'(ctrl), 8'h03);
    press(20, 3 * STEP + 4);
    chk("t4_m0", 8'(ctrl), 8'h00);
    chk("t4_led", led, 8'h00);

    // mode change landing on a step tick in mode1
    do_reset();
    press(20, 20);
    for (int i = 0; i < STEP; i++) begin
      if (((t + 1 + DB + 3 - load_edge) % STEP) == 0) break;
      cyc(1'b1);
    end
    repeat (DB + 4) cyc(1'b0);
    chk("t5_load", led, 8'h80);
    repeat (STEP - 1) cyc(1'b0);
    chk("t5_hold", led, 8'h80);
    cyc(1'b0);
    chk("t5_step", led, 8'h40);
    repeat (20) cyc(1'b1);

    // async reset mid-debounce in mode3 while the pattern is dark
    press(20, 20);
    chk("t6_m3", 8'(ctrl), 8'h03);
    for (int i = 0; i < 3 * STEP; i++) begin
      if (led_exp() == 8'h00 && ((t - load_edge) % STEP) < STEP - DB) break;
      cyc(1'b1);
    end
    chk("t6_dark", led, 8'h00);
    repeat (DB / 2) cyc(1'b0);
    rst_n = 1'b0;
    key   = 1'b1;
    #1;
    chk("t6_async_ctrl", 8'(ctrl), 8'h00);
    chk("t6_async_led", led, 8'h00);
    model_reset();
    repeat (3) cyc(1'b1);
    rst_n = 1'b1;
    repeat (40) cyc(1'b1);
    chk("t6_discard", 8'(ctrl), 8'h00);

    // randomized key activity
    repeat (400) begin
      logic kv;
      int   len;
      kv  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * DB + 2);
      repeat (len) cyc(kv);
    end
    repeat (30) cyc(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
